// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-rate tick generator for the UART datapath. Instead of deriving slow
// clocks it produces single-cycle enable pulses in the sys_clk domain. A
// programmable integer + fractional divisor sets the oversample period. The TX
// bit-rate chain and the RX oversample chain run independently. The RX chain
// can be re-phased to a start-bit edge with rx_sync.
//
// Period of one oversample interval, per chain:
//   period = max(active_int, 2) + carry
//   carry  = carry-out of (frac_acc + active_frac), taken at each reload
// The long-run average period is therefore int + frac / 2^FRAC_W cycles.
//
// Optional feature macro: UART_LEGACY_CLK_EN
//   When defined, adds uart_tx_clk / uart_rx_clk, square waves that toggle on
//   every tx_tick / rx_os_tick and hold their level while en is low.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   generator enable; low holds both chains cleared
//   div_int     in   requested integer divisor (oversample period, cycles)
//   div_frac    in   requested fractional divisor (1/2^FRAC_W cycle units)
//   div_load    in   strobe: capture div_int/div_frac into the shadow
//   div_ack     out  pulse: shadow divisor became active
//   tx_tick     out  pulse once per TX bit period (OVS oversample periods)
//   rx_os_tick  out  pulse once per RX oversample period
//   rx_sample   out  pulse at RX bit centre (rx_phase becomes OVS/2)
//   rx_phase    out  RX oversample index within the current bit
//   rx_sync     in   strobe: restart RX chain at phase 0
//   uart_tx_clk out  (UART_LEGACY_CLK_EN only) toggles on tx_tick
//   uart_rx_clk out  (UART_LEGACY_CLK_EN only) toggles on rx_os_tick
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int RST_DIV_INT  = 195,
    parameter int RST_DIV_FRAC = 5
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    output logic                    div_ack,
    output logic                    tx_tick,
    output logic                    rx_os_tick,
    output logic                    rx_sample,
    output logic [$clog2(OVS)-1:0]  rx_phase,
    input  logic                    rx_sync
`ifdef UART_LEGACY_CLK_EN
    ,
    output logic                    uart_tx_clk,
    output logic                    uart_rx_clk
`endif
);

    localparam int PH_W = $clog2(OVS);
    localparam logic [DIV_W:0] MIN_PERIOD = (DIV_W+1)'(2);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_CENTRE = PH_W'(OVS / 2);

    // Divisor registers: shadow takes loads, active feeds both chains.
    logic [DIV_W-1:0]  act_int_reg;
    logic [FRAC_W-1:0] act_frac_reg;
    logic [DIV_W-1:0]  shd_int_reg;
    logic [FRAC_W-1:0] shd_frac_reg;
    logic              pending_reg;
    logic              div_ack_reg;
    logic              xfer;

    // Chain 0 = TX, chain 1 = RX. Only RX can be restarted externally.
    logic [1:0] restart;
    logic [1:0] period_end;

    assign restart[0] = 1'b0;
    assign restart[1] = rx_sync;

    // -------------------------------------------------------------------------
    // Period counters. cnt_reg counts down to 1; the edge that sees 1 is the
    // period end and reloads. cnt_reg == 0 only right after reset / disable,
    // so the first enabled edge reloads without a tick and the first period
    // ends exactly `period` edges later.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chain
            logic [DIV_W:0]  cnt_reg;
            logic [FRAC_W-1:0] acc_reg;
            logic [FRAC_W:0] acc_sum;
            logic [DIV_W:0]  base_period;

            assign acc_sum     = {1'b0, acc_reg} + {1'b0, act_frac_reg};
            assign base_period = (act_int_reg < DIV_W'(2)) ? MIN_PERIOD
                                                           : {1'b0, act_int_reg};
            assign period_end[gi] = en && !restart[gi] &&
                                    (cnt_reg == (DIV_W+1)'(1));

            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                    acc_reg <= '0;
                end else if (!en) begin
                    cnt_reg <= '0;
                    acc_reg <= '0;
                end else if (restart[gi]) begin
                    // Accumulator restarts from zero, so no carry this period.
                    cnt_reg <= base_period;
                    acc_reg <= act_frac_reg;
                end else if (cnt_reg <= (DIV_W+1)'(1)) begin
                    cnt_reg <= base_period + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
                    acc_reg <= acc_sum[FRAC_W-1:0];
                end else begin
                    cnt_reg <= cnt_reg - (DIV_W+1)'(1);
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // TX: oversample index, tick on wrap OVS-1 -> 0.
    // -------------------------------------------------------------------------
    logic [PH_W-1:0] tx_idx_reg;
    logic            tx_tick_reg;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tx_idx_reg  <= '0;
            tx_tick_reg <= 1'b0;
        end else if (!en) begin
            tx_idx_reg  <= '0;
            tx_tick_reg <= 1'b0;
        end else begin
            tx_tick_reg <= 1'b0;
            if (period_end[0]) begin
                if (tx_idx_reg == PH_LAST) begin
                    tx_idx_reg  <= '0;
                    tx_tick_reg <= 1'b1;
                end else begin
                    tx_idx_reg <= tx_idx_reg + PH_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // RX: phase counter, oversample tick, bit-centre sample strobe.
    // rx_sync clears the phase and suppresses any coincident tick.
    // -------------------------------------------------------------------------
    logic [PH_W-1:0] rx_phase_reg;
    logic [PH_W-1:0] rx_phase_next;
    logic            rx_os_tick_reg;
    logic            rx_sample_reg;

    assign rx_phase_next = rx_phase_reg + PH_W'(1);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_phase_reg   <= '0;
            rx_os_tick_reg <= 1'b0;
            rx_sample_reg  <= 1'b0;
        end else if (!en || rx_sync) begin
            rx_phase_reg   <= '0;
            rx_os_tick_reg <= 1'b0;
            rx_sample_reg  <= 1'b0;
        end else begin
            rx_os_tick_reg <= period_end[1];
            rx_sample_reg  <= period_end[1] && (rx_phase_next == PH_CENTRE);
            if (period_end[1]) begin
                rx_phase_reg <= rx_phase_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Divisor handshake. A pending shadow becomes active at a TX period end
    // (or immediately next cycle while disabled). The reload on that same
    // edge still uses the old active value, so a running period is never
    // altered. A load on the transfer edge re-arms pending with the new value.
    // -------------------------------------------------------------------------
    assign xfer = pending_reg && (!en || period_end[0]);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            act_int_reg  <= DIV_W'(RST_DIV_INT);
            act_frac_reg <= FRAC_W'(RST_DIV_FRAC);
            shd_int_reg  <= DIV_W'(RST_DIV_INT);
            shd_frac_reg <= FRAC_W'(RST_DIV_FRAC);
            pending_reg  <= 1'b0;
            div_ack_reg  <= 1'b0;
        end else begin
            div_ack_reg <= 1'b0;
            if (xfer) begin
                act_int_reg  <= shd_int_reg;
                act_frac_reg <= shd_frac_reg;
                pending_reg  <= 1'b0;
                div_ack_reg  <= 1'b1;
            end
            if (div_load) begin
                shd_int_reg  <= div_int;
                shd_frac_reg <= div_frac;
                pending_reg  <= 1'b1;
            end
        end
    end

`ifdef UART_LEGACY_CLK_EN
    // Legacy square-wave clocks: toggle on the same edge that raises the tick.
    logic uart_tx_clk_reg;
    logic uart_rx_clk_reg;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            uart_tx_clk_reg <= 1'b0;
            uart_rx_clk_reg <= 1'b0;
        end else begin
            if (period_end[0] && (tx_idx_reg == PH_LAST)) begin
                uart_tx_clk_reg <= !uart_tx_clk_reg;
            end
            if (period_end[1]) begin
                uart_rx_clk_reg <= !uart_rx_clk_reg;
            end
        end
    end

    assign uart_tx_clk = uart_tx_clk_reg;
    assign uart_rx_clk = uart_rx_clk_reg;
`endif

    assign div_ack    = div_ack_reg;
    assign tx_tick    = tx_tick_reg;
    assign rx_os_tick = rx_os_tick_reg;
    assign rx_sample  = rx_sample_reg;
    assign rx_phase   = rx_phase_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Directed bench for uart_baud_gen. A timestamp-based model predicts, for each
// clock edge, which ticks fire (period ends are absolute cycle numbers, bits
// are counted in whole periods). One compare process checks every cycle; the
// directed sequence adds literal checks on spacings and latencies.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
    localparam int FMOD   = 1 << FRAC_W;

    logic        sys_clk  = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic [15:0] div_int  = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        rx_sync  = 1'b0;
    logic        div_ack;
    logic        tx_tick;
    logic        rx_os_tick;
    logic        rx_sample;
    logic [3:0]  rx_phase;
`ifdef UART_LEGACY_CLK_EN
    logic        uart_tx_clk;
    logic        uart_rx_clk;
`endif

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
        .RST_DIV_INT(195), .RST_DIV_FRAC(5)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .en         (en),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .tx_tick    (tx_tick),
        .rx_os_tick (rx_os_tick),
        .rx_sample  (rx_sample),
        .rx_phase   (rx_phase),
        .rx_sync    (rx_sync)
`ifdef UART_LEGACY_CLK_EN
        ,
        .uart_tx_clk(uart_tx_clk),
        .uart_rx_clk(uart_rx_clk)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    // ------------------------------------------------------------------ model
    int cyc = 0;
    int act_int = 195, act_frac = 5, shd_int = 195, shd_frac = 5;
    bit pending = 0;
    bit en_prev = 0;
    bit tx_run = 0, rx_run = 0;
    int tx_next = 0, rx_next = 0, tx_acc = 0, rx_acc = 0, tx_n = 0, rx_n = 0;
    int en_edge_cyc = -1, sync_cyc = -1;
    bit e_ack = 0, e_tx = 0, e_rxt = 0, e_smp = 0, e_txclk = 0, e_rxclk = 0;
    int e_phase = 0;

    function automatic int per_of(input int acc);
        int base;
        base = (act_int < 2) ? 2 : act_int;
        return base + (((acc + act_frac) >= FMOD) ? 1 : 0);
    endfunction

    function automatic int acc_of(input int acc);
        return (acc + act_frac) % FMOD;
    endfunction

    always @(posedge sys_clk) begin
        bit tx_end;
        cyc++;
        e_ack = 0; e_tx = 0; e_rxt = 0; e_smp = 0;
        tx_end = 0;
        if (rst) begin
            act_int = 195; act_frac = 5; shd_int = 195; shd_frac = 5;
            pending = 0; en_prev = 0; tx_run = 0; rx_run = 0;
            tx_n = 0; rx_n = 0; e_txclk = 0; e_rxclk = 0;
        end else begin
            if (!en) begin
                tx_run = 0; rx_run = 0; tx_n = 0; rx_n = 0;
            end else begin
                if (!en_prev) en_edge_cyc = cyc;
                if (!tx_run) begin
                    tx_run = 1; tx_acc = 0; tx_n = 0;
                    tx_next = cyc + per_of(tx_acc); tx_acc = acc_of(tx_acc);
                end else if (cyc == tx_next) begin
                    tx_end = 1; tx_n++;
                    if (tx_n % OVS == 0) begin e_tx = 1; e_txclk = !e_txclk; end
                    tx_next = cyc + per_of(tx_acc); tx_acc = acc_of(tx_acc);
                end
                if (rx_sync) begin
                    rx_run = 1; rx_acc = 0; rx_n = 0; sync_cyc = cyc;
                    rx_next = cyc + per_of(rx_acc); rx_acc = acc_of(rx_acc);
                end else if (!rx_run) begin
                    rx_run = 1; rx_acc = 0; rx_n = 0;
                    rx_next = cyc + per_of(rx_acc); rx_acc = acc_of(rx_acc);
                end else if (cyc == rx_next) begin
                    rx_n++; e_rxt = 1; e_rxclk = !e_rxclk;
                    e_smp = ((rx_n % OVS) == OVS / 2);
                    rx_next = cyc + per_of(rx_acc); rx_acc = acc_of(rx_acc);
                end
            end
            if (pending && (!en || tx_end)) begin
                act_int = shd_int; act_frac = shd_frac; pending = 0; e_ack = 1;
            end
            if (div_load) begin
                shd_int = div_int; shd_frac = div_frac; pending = 1;
            end
            en_prev = en;
        end
        e_phase = rx_n % OVS;
    end

    // ------------------------------------------------------- compare process
    int last_rx = 0, rx_gap = 0, rx_cnt = 0, last_tx = 0, tx_gap = 0, tx_lat = 0;
    int ack_cnt = 0, smp_phase = -1, first_lat = -1, seen_edge = -1, since_sync = -1;
    int gap_q[$];

    always @(posedge sys_clk) begin
        logic [9:0] got, expv;
        #2;
        got  = {2'b00, div_ack, tx_tick, rx_os_tick, rx_sample, rx_phase};
        expv = {2'b00, e_ack, e_tx, e_rxt, e_smp, 4'(e_phase)};
`ifdef UART_LEGACY_CLK_EN
        got[9:8]  = {uart_tx_clk, uart_rx_clk};
        expv[9:8] = {e_txclk, e_rxclk};
`endif
        check($sformatf("outputs@cyc%0d", cyc), int'(got), int'(expv));
        if (div_ack) ack_cnt++;
        if (rx_sample) smp_phase = rx_phase;
        if (tx_tick) begin
            tx_gap = cyc - last_tx; last_tx = cyc; tx_lat = cyc - en_edge_cyc;
        end
        if (rx_os_tick) begin
            rx_gap = cyc - last_rx; last_rx = cyc; rx_cnt++;
            gap_q.push_back(rx_gap);
            since_sync = cyc - sync_cyc;
            if (en_edge_cyc != seen_edge) begin
                first_lat = cyc - en_edge_cyc;
                seen_edge = en_edge_cyc;
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic run(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic load(input int i, input int f);
        @(negedge sys_clk);
        div_int = 16'(i); div_frac = 4'(f); div_load = 1'b1;
        @(negedge sys_clk);
        div_load = 1'b0;
    endtask

    task automatic start(input int i, input int f);
        @(negedge sys_clk) en = 1'b0;
        load(i, f);
        run(3);
        @(negedge sys_clk) en = 1'b1;
    endtask

    task automatic wait_rx_tick(input string name);
        int k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!rx_os_tick && k < 20);
        check({name, " tick seen"}, int'(rx_os_tick), 1);
    endtask

    initial begin
        int a0, qi, sum, base, k;

        // Reset state
        run(3);
        check("reset outputs", int'({div_ack, tx_tick, rx_os_tick, rx_sample}), 0);
        check("reset rx_phase", int'(rx_phase), 0);
        @(negedge sys_clk) rst = 1'b0;
        $display("txn reset: outputs idle");

        // T1: int=4 frac=0
        start(4, 0);
        a0 = ack_cnt;
        run(140);
        check("T1 rx spacing", rx_gap, 4);
        check("T1 tx spacing", tx_gap, 64);
        check("T1 first tick latency", first_lat, 4);
        check("T1 sample phase", smp_phase, 8);
        check("T1 no div_ack", ack_cnt - a0, 0);
        $display("txn T1 int=4: rx gap %0d tx gap %0d", rx_gap, tx_gap);

        // T2: int=4 frac=8 -> periods 4,5 alternating
        start(4, 8);
        run(200);
        sum = 0;
        for (int i = gap_q.size() - 16; i < gap_q.size(); i++) sum += gap_q[i];
        check("T2 16 periods span", sum, 72);
        check("T2 tx spacing", tx_gap, 72);
        check("T2 adjacent pair", gap_q[gap_q.size()-1] + gap_q[gap_q.size()-2], 9);
        $display("txn T2 int=4 frac=8: 16-period span %0d", sum);

        // T3: defaults 195 + 5/16 over 256 periods: 256*195 + 80 = 50000
        start(195, 5);
        base = rx_cnt;
        k = 0;
        while ((rx_cnt - base) < 256 && k < 52000) begin
            @(negedge sys_clk);
            k++;
        end
        check("T3 256 periods reached", int'((rx_cnt - base) >= 256), 1);
        check("T3 256 periods span", last_rx - en_edge_cyc, 50000);
        $display("txn T3 int=195 frac=5: 256 periods in %0d cycles", last_rx - en_edge_cyc);

        // T4: two loads while pending, last wins, old period completes
        start(12, 0);
        run(30);
        a0 = ack_cnt;
        qi = gap_q.size();
        load(10, 0);
        load(6, 0);
        run(40);
        check("T4 single div_ack", ack_cnt - a0, 1);
        check("T4 enough ticks", int'(gap_q.size() > qi + 2), 1);
        if (gap_q.size() > qi + 2) begin
            check("T4 in-flight period", gap_q[qi], 12);
            check("T4 reload at transfer", gap_q[qi+1], 12);
            check("T4 new spacing", gap_q[gap_q.size()-1], 6);
        end
        $display("txn T4 load 10 then 6: acks %0d last gap %0d", ack_cnt - a0, rx_gap);

        // T5: rx_sync coincident with rx_os_tick at int=8
        start(8, 0);
        wait_rx_tick("T5");
        run(7);
        rx_sync = 1'b1;
        @(negedge sys_clk);
        rx_sync = 1'b0;
        check("T5 tick suppressed", int'(rx_os_tick), 0);
        check("T5 phase cleared", int'(rx_phase), 0);
        run(12);
        check("T5 tick after sync", since_sync, 8);
        run(110);
        check("T5 tx unaffected", tx_lat, 128);
        $display("txn T5 rx_sync: next tick +%0d tx at %0d", since_sync, tx_lat);

        // T6: int=0 and int=1 clamp to 2; reset mid-operation
        start(0, 0);
        run(20);
        check("T6 int=0 spacing", rx_gap, 2);
        start(1, 0);
        run(20);
        check("T6 int=1 spacing", rx_gap, 2);
        wait_rx_tick("T6");
        rst = 1'b1;
        #1;
        check("T6 async reset outputs", int'({div_ack, tx_tick, rx_os_tick, rx_sample, rx_phase}), 0);
        en = 1'b0;
        run(2);
        @(negedge sys_clk) rst = 1'b0;
        $display("txn T6 clamp and reset: gap %0d", rx_gap);

        // T7: en low then high restarts the chains
        start(5, 0);
        run(12);
        @(negedge sys_clk) en = 1'b0;
        run(3);
        @(negedge sys_clk) en = 1'b1;
        run(12);
        check("T7 restart latency", first_lat, 5);
        $display("txn T7 re-enable: first tick after %0d cycles", first_lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
